// File: rtl/mcu_shared_pkg.sv
// Shared types and constants for the CPU/MCU shared-RAM responder.
package mcu_shared_pkg;

   typedef enum logic {GRANT_CPU = 1'b0, GRANT_MCU = 1'b1} grant_t;

   localparam logic [11:0] DEF_MCU_MBOX_ADDR = 12'hFFF;
   localparam logic [11:0] DEF_CPU_MBOX_ADDR = 12'hFFE;

   typedef struct packed {
      logic [11:0] addr;
      logic [15:0] data;
      logic [1:0]  be;
      logic        we;
   } req_t;

   // True when the request's enabled bytes include byte address a.
   function automatic logic covers(input req_t r, input logic [11:0] a);
      return ((r.addr | 12'h001) == (a | 12'h001)) && r.be[a[0]];
   endfunction

endpackage

// File: rtl/shared_ram_bank.sv
// 2048x8 single-port synchronous RAM bank with registered read data; no reset.
module shared_ram_bank (
   input  logic        clk,
   input  logic        en,
   input  logic        we,
   input  logic [10:0] addr,
   input  logic [7:0]  din,
   output logic [7:0]  dout
);

   logic [7:0] mem_q [0:2047];
   logic [7:0] dout_q;

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem_q[addr] <= din;
         end
         dout_q <= mem_q[addr];
      end
   end

   assign dout = dout_q;

endmodule

// File: rtl/mcu_shared_ram.sv
// Shared RAM responder: CPU (16-bit) and MCU (8-bit) ports, round-robin
// arbitration of one access per clock, and the two mailbox interrupt flags.
module mcu_shared_ram
   import mcu_shared_pkg::*;
#(
   parameter logic [11:0] MCU_MBOX_ADDR = DEF_MCU_MBOX_ADDR,
   parameter logic [11:0] CPU_MBOX_ADDR = DEF_CPU_MBOX_ADDR
) (
   input  logic        CLK_32M,
   input  logic        reset_n,
   input  logic [10:0] cpu_addr,
   input  logic [15:0] cpu_din,
   input  logic [1:0]  cpu_be,
   input  logic        cpu_we,
   input  logic        cpu_req,
   output logic [15:0] cpu_dout,
   output logic        cpu_ack,
   output logic        cpu_int,
   input  logic        cpu_int_ack,
   input  logic [11:0] mcu_addr,
   input  logic [7:0]  mcu_din,
   input  logic        mcu_we,
   input  logic        mcu_req,
   output logic [7:0]  mcu_dout,
   output logic        mcu_ack,
   output logic        mcu_int
);

   req_t        cpu_req_q, cpu_req_d, mcu_req_q, mcu_req_d;
   req_t        cpu_in_s, mcu_in_s, cpu_cur_s, mcu_cur_s;
   logic        cpu_pend_q, cpu_pend_d, mcu_pend_q, mcu_pend_d;
   logic        cpu_ack_q, cpu_ack_d, mcu_ack_q, mcu_ack_d;
   logic        cpu_rd_q, cpu_rd_d, mcu_rd_q, mcu_rd_d;
   logic        mcu_odd_q, mcu_odd_d;
   logic        cpu_int_q, cpu_int_d, mcu_int_q, mcu_int_d;
   logic [15:0] cpu_hold_q, cpu_hold_d;
   logic [7:0]  mcu_hold_q, mcu_hold_d;
   grant_t      last_q, last_d;
   logic        cpu_strobe_s, mcu_strobe_s, cpu_cand_s, mcu_cand_s;
   logic        gnt_cpu_s, gnt_mcu_s, gnt_any_s;
   logic [10:0] bank_addr_s;
   logic [15:0] bank_data_s;
   logic [1:0]  bank_be_s;
   logic        bank_we_s;
   logic [7:0]  even_rd_s, odd_rd_s;

   // Request capture, arbitration and bank steering.
   always_comb begin
      cpu_in_s     = '{addr: {cpu_addr, 1'b0}, data: cpu_din, be: cpu_be, we: cpu_we};
      mcu_in_s     = '{addr: mcu_addr, data: {mcu_din, mcu_din},
                       be: (mcu_addr[0] ? 2'b10 : 2'b01), we: mcu_we};
      // Strobes during a pending request or an ack cycle are protocol violations.
      cpu_strobe_s = cpu_req && !cpu_pend_q && !cpu_ack_q;
      mcu_strobe_s = mcu_req && !mcu_pend_q && !mcu_ack_q;
      cpu_cand_s   = cpu_pend_q || cpu_strobe_s;
      mcu_cand_s   = mcu_pend_q || mcu_strobe_s;
      cpu_cur_s    = cpu_pend_q ? cpu_req_q : cpu_in_s;
      mcu_cur_s    = mcu_pend_q ? mcu_req_q : mcu_in_s;
      if (cpu_cand_s && mcu_cand_s) begin
         gnt_cpu_s = (last_q == GRANT_MCU);
      end else begin
         gnt_cpu_s = cpu_cand_s;
      end
      gnt_mcu_s   = mcu_cand_s && !gnt_cpu_s;
      gnt_any_s   = gnt_cpu_s || gnt_mcu_s;
      bank_addr_s = gnt_cpu_s ? cpu_cur_s.addr[11:1] : mcu_cur_s.addr[11:1];
      bank_data_s = gnt_cpu_s ? cpu_cur_s.data : mcu_cur_s.data;
      bank_be_s   = gnt_cpu_s ? cpu_cur_s.be : mcu_cur_s.be;
      bank_we_s   = gnt_cpu_s ? cpu_cur_s.we : mcu_cur_s.we;
   end

   // Next-state for request registers, acks, read-data hold and mailbox flags.
   always_comb begin
      cpu_req_d  = cpu_strobe_s ? cpu_in_s : cpu_req_q;
      mcu_req_d  = mcu_strobe_s ? mcu_in_s : mcu_req_q;
      cpu_pend_d = cpu_cand_s && !gnt_cpu_s;
      mcu_pend_d = mcu_cand_s && !gnt_mcu_s;
      cpu_ack_d  = gnt_cpu_s;
      mcu_ack_d  = gnt_mcu_s;
      cpu_rd_d   = gnt_cpu_s && !cpu_cur_s.we;
      mcu_rd_d   = gnt_mcu_s && !mcu_cur_s.we;
      mcu_odd_d  = gnt_mcu_s ? mcu_cur_s.addr[0] : mcu_odd_q;
      cpu_hold_d = cpu_rd_q ? {odd_rd_s, even_rd_s} : cpu_hold_q;
      mcu_hold_d = mcu_rd_q ? (mcu_odd_q ? odd_rd_s : even_rd_s) : mcu_hold_q;
      if (gnt_cpu_s) begin
         last_d = GRANT_CPU;
      end else if (gnt_mcu_s) begin
         last_d = GRANT_MCU;
      end else begin
         last_d = last_q;
      end
      if (gnt_cpu_s && cpu_cur_s.we && covers(cpu_cur_s, MCU_MBOX_ADDR)) begin
         mcu_int_d = 1'b1;
      end else if (gnt_mcu_s && !mcu_cur_s.we && covers(mcu_cur_s, MCU_MBOX_ADDR)) begin
         mcu_int_d = 1'b0;
      end else begin
         mcu_int_d = mcu_int_q;
      end
      // Set beats a coincident acknowledge.
      if (gnt_mcu_s && mcu_cur_s.we && covers(mcu_cur_s, CPU_MBOX_ADDR)) begin
         cpu_int_d = 1'b1;
      end else if (cpu_int_ack) begin
         cpu_int_d = 1'b0;
      end else begin
         cpu_int_d = cpu_int_q;
      end
   end

   // State registers.
   always_ff @(posedge CLK_32M or negedge reset_n) begin
      if (!reset_n) begin
         cpu_req_q  <= '0;
         mcu_req_q  <= '0;
         cpu_pend_q <= 1'b0;
         mcu_pend_q <= 1'b0;
         cpu_ack_q  <= 1'b0;
         mcu_ack_q  <= 1'b0;
         cpu_rd_q   <= 1'b0;
         mcu_rd_q   <= 1'b0;
         mcu_odd_q  <= 1'b0;
         cpu_hold_q <= 16'h0000;
         mcu_hold_q <= 8'h00;
         cpu_int_q  <= 1'b0;
         mcu_int_q  <= 1'b0;
         last_q     <= GRANT_MCU;
      end else begin
         cpu_req_q  <= cpu_req_d;
         mcu_req_q  <= mcu_req_d;
         cpu_pend_q <= cpu_pend_d;
         mcu_pend_q <= mcu_pend_d;
         cpu_ack_q  <= cpu_ack_d;
         mcu_ack_q  <= mcu_ack_d;
         cpu_rd_q   <= cpu_rd_d;
         mcu_rd_q   <= mcu_rd_d;
         mcu_odd_q  <= mcu_odd_d;
         cpu_hold_q <= cpu_hold_d;
         mcu_hold_q <= mcu_hold_d;
         cpu_int_q  <= cpu_int_d;
         mcu_int_q  <= mcu_int_d;
         last_q     <= last_d;
      end
   end

   shared_ram_bank u_bank_even (
      .clk  (CLK_32M),
      .en   (gnt_any_s),
      .we   (gnt_any_s && bank_we_s && bank_be_s[0]),
      .addr (bank_addr_s),
      .din  (bank_data_s[7:0]),
      .dout (even_rd_s)
   );

   shared_ram_bank u_bank_odd (
      .clk  (CLK_32M),
      .en   (gnt_any_s),
      .we   (gnt_any_s && bank_we_s && bank_be_s[1]),
      .addr (bank_addr_s),
      .din  (bank_data_s[15:8]),
      .dout (odd_rd_s)
   );

   assign cpu_dout = cpu_rd_q ? {odd_rd_s, even_rd_s} : cpu_hold_q;
   assign mcu_dout = mcu_rd_q ? (mcu_odd_q ? odd_rd_s : even_rd_s) : mcu_hold_q;
   assign cpu_ack  = cpu_ack_q;
   assign mcu_ack  = mcu_ack_q;
   assign cpu_int  = cpu_int_q;
   assign mcu_int  = mcu_int_q;

endmodule

// File: tb/tb_mcu_shared_ram.sv
// Directed bench for mcu_shared_ram: per-cycle vector table plus hand-written
// sequences for contention, protocol violations and mid-operation reset.
module tb_mcu_shared_ram;

   logic        CLK_32M = 1'b0;
   logic        reset_n = 1'b0;
   logic [10:0] cpu_addr = 11'h000;
   logic [15:0] cpu_din = 16'h0000;
   logic [1:0]  cpu_be = 2'b00;
   logic        cpu_we = 1'b0;
   logic        cpu_req = 1'b0;
   logic [15:0] cpu_dout;
   logic        cpu_ack;
   logic        cpu_int;
   logic        cpu_int_ack = 1'b0;
   logic [11:0] mcu_addr = 12'h000;
   logic [7:0]  mcu_din = 8'h00;
   logic        mcu_we = 1'b0;
   logic        mcu_req = 1'b0;
   logic [7:0]  mcu_dout;
   logic        mcu_ack;
   logic        mcu_int;

   int n_vec = 0;
   int n_fail = 0;

   typedef struct {
      logic        cr; logic cw; logic [10:0] ca; logic [15:0] cd; logic [1:0] cbe;
      logic        mr; logic mw; logic [11:0] ma; logic [7:0] md;
      logic        ia;
      logic        eca; logic [15:0] ecd;
      logic        ema; logic [7:0] emd;
      logic        eci; logic emi;
   } vec_t;

   vec_t vq[$];

   mcu_shared_ram dut (
      .CLK_32M(CLK_32M), .reset_n(reset_n),
      .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_be(cpu_be), .cpu_we(cpu_we),
      .cpu_req(cpu_req), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_int(cpu_int),
      .cpu_int_ack(cpu_int_ack),
      .mcu_addr(mcu_addr), .mcu_din(mcu_din), .mcu_we(mcu_we), .mcu_req(mcu_req),
      .mcu_dout(mcu_dout), .mcu_ack(mcu_ack), .mcu_int(mcu_int)
   );

   always #5 CLK_32M = ~CLK_32M;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK_32M);
      #1;
   endtask

   task automatic set_cpu(input logic r, input logic w, input logic [10:0] a,
                          input logic [15:0] d, input logic [1:0] be);
      cpu_req = r; cpu_we = w; cpu_addr = a; cpu_din = d; cpu_be = be;
   endtask

   task automatic set_mcu(input logic r, input logic w, input logic [11:0] a,
                          input logic [7:0] d);
      mcu_req = r; mcu_we = w; mcu_addr = a; mcu_din = d;
   endtask

   task automatic idle();
      set_cpu(1'b0, 1'b0, 11'h000, 16'h0000, 2'b00);
      set_mcu(1'b0, 1'b0, 12'h000, 8'h00);
      cpu_int_ack = 1'b0;
   endtask

   task automatic chk_all(input string tag, input logic eca, input logic [15:0] ecd,
                          input logic ema, input logic [7:0] emd,
                          input logic eci, input logic emi);
      chk({tag, " cpu_ack"}, {15'd0, cpu_ack}, {15'd0, eca});
      chk({tag, " cpu_dout"}, cpu_dout, ecd);
      chk({tag, " mcu_ack"}, {15'd0, mcu_ack}, {15'd0, ema});
      chk({tag, " mcu_dout"}, {8'd0, mcu_dout}, {8'd0, emd});
      chk({tag, " cpu_int"}, {15'd0, cpu_int}, {15'd0, eci});
      chk({tag, " mcu_int"}, {15'd0, mcu_int}, {15'd0, emi});
   endtask

   // Shorthand for an idle vector with the expected outputs.
   function automatic vec_t vi(input logic eca, input logic [15:0] ecd, input logic ema,
                               input logic [7:0] emd, input logic eci, input logic emi,
                               input logic ia);
      return '{1'b0, 1'b0, 11'h000, 16'h0000, 2'b00, 1'b0, 1'b0, 12'h000, 8'h00, ia,
               eca, ecd, ema, emd, eci, emi};
   endfunction

   initial begin
      // cr cw ca cd cbe | mr mw ma md | ia | eca ecd ema emd eci emi
      vq.push_back('{1'b1, 1'b1, 11'h010, 16'hBEEF, 2'b11, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0});
      vq.push_back(vi(1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
      vq.push_back('{1'b1, 1'b0, 11'h010, 16'h0000, 2'b00, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 16'hBEEF, 1'b0, 8'h00, 1'b0, 1'b0});
      vq.push_back(vi(1'b0, 16'hBEEF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
      vq.push_back('{1'b0, 1'b0, 11'h000, 16'h0000, 2'b00, 1'b1, 1'b0, 12'h020, 8'h00, 1'b0, 1'b0, 16'hBEEF, 1'b1, 8'hEF, 1'b0, 1'b0});
      vq.push_back(vi(1'b0, 16'hBEEF, 1'b0, 8'hEF, 1'b0, 1'b0, 1'b0));
      vq.push_back('{1'b0, 1'b0, 11'h000, 16'h0000, 2'b00, 1'b1, 1'b0, 12'h021, 8'h00, 1'b0, 1'b0, 16'hBEEF, 1'b1, 8'hBE, 1'b0, 1'b0});
      vq.push_back(vi(1'b0, 16'hBEEF, 1'b0, 8'hBE, 1'b0, 1'b0, 1'b0));
      vq.push_back('{1'b1, 1'b1, 11'h011, 16'hFFFF, 2'b11, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 16'hBEEF, 1'b0, 8'hBE, 1'b0, 1'b0});
      vq.push_back(vi(1'b0, 16'hBEEF, 1'b0, 8'hBE, 1'b0, 1'b0, 1'b0));
      vq.push_back('{1'b1, 1'b1, 11'h011, 16'h1234, 2'b01, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 16'hBEEF, 1'b0, 8'hBE, 1'b0, 1'b0});
      vq.push_back(vi(1'b0, 16'hBEEF, 1'b0, 8'hBE, 1'b0, 1'b0, 1'b0));
      vq.push_back('{1'b1, 1'b0, 11'h011, 16'h0000, 2'b00, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 16'hFF34, 1'b0, 8'hBE, 1'b0, 1'b0});
      vq.push_back(vi(1'b0, 16'hFF34, 1'b0, 8'hBE, 1'b0, 1'b0, 1'b0));
      vq.push_back('{1'b1, 1'b1, 11'h011, 16'hABCD, 2'b00, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 16'hFF34, 1'b0, 8'hBE, 1'b0, 1'b0});
      vq.push_back(vi(1'b0, 16'hFF34, 1'b0, 8'hBE, 1'b0, 1'b0, 1'b0));
      vq.push_back('{1'b1, 1'b0, 11'h011, 16'h0000, 2'b00, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 16'hFF34, 1'b0, 8'hBE, 1'b0, 1'b0});
      vq.push_back(vi(1'b0, 16'hFF34, 1'b0, 8'hBE, 1'b0, 1'b0, 1'b0));
      // Mailbox round trip.
      vq.push_back('{1'b1, 1'b1, 11'h7FF, 16'h5A00, 2'b10, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 16'hFF34, 1'b0, 8'hBE, 1'b0, 1'b1});
      vq.push_back('{1'b0, 1'b0, 11'h000, 16'h0000, 2'b00, 1'b1, 1'b1, 12'hFFF, 8'h77, 1'b0, 1'b0, 16'hFF34, 1'b1, 8'hBE, 1'b0, 1'b1});
      vq.push_back(vi(1'b0, 16'hFF34, 1'b0, 8'hBE, 1'b0, 1'b1, 1'b0));
      vq.push_back('{1'b0, 1'b0, 11'h000, 16'h0000, 2'b00, 1'b1, 1'b0, 12'hFFF, 8'h00, 1'b0, 1'b0, 16'hFF34, 1'b1, 8'h77, 1'b0, 1'b0});
      vq.push_back(vi(1'b0, 16'hFF34, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0));
      vq.push_back('{1'b0, 1'b0, 11'h000, 16'h0000, 2'b00, 1'b1, 1'b1, 12'hFFE, 8'h11, 1'b0, 1'b0, 16'hFF34, 1'b1, 8'h77, 1'b1, 1'b0});
      vq.push_back(vi(1'b0, 16'hFF34, 1'b0, 8'h77, 1'b1, 1'b0, 1'b0));
      vq.push_back('{1'b0, 1'b0, 11'h000, 16'h0000, 2'b00, 1'b1, 1'b1, 12'hFFE, 8'h22, 1'b1, 1'b0, 16'hFF34, 1'b1, 8'h77, 1'b1, 1'b0});
      vq.push_back(vi(1'b0, 16'hFF34, 1'b0, 8'h77, 1'b0, 1'b0, 1'b1));
      vq.push_back(vi(1'b0, 16'hFF34, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0));
      vq.push_back('{1'b1, 1'b0, 11'h7FF, 16'h0000, 2'b00, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 16'h7722, 1'b0, 8'h77, 1'b0, 1'b0});
      vq.push_back(vi(1'b0, 16'h7722, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0));

      // Reset state.
      tick(); tick();
      chk_all("reset", 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0);
      reset_n = 1'b1;

      // Table: inputs applied for one cycle, outputs checked after that edge.
      foreach (vq[i]) begin
         set_cpu(vq[i].cr, vq[i].cw, vq[i].ca, vq[i].cd, vq[i].cbe);
         set_mcu(vq[i].mr, vq[i].mw, vq[i].ma, vq[i].md);
         cpu_int_ack = vq[i].ia;
         tick();
         chk_all($sformatf("vec%0d", i), vq[i].eca, vq[i].ecd, vq[i].ema, vq[i].emd,
                 vq[i].eci, vq[i].emi);
      end
      idle();

      // Reset clears outputs; simultaneous strobes then favour the CPU.
      reset_n = 1'b0;
      tick();
      chk_all("rst2", 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0);
      reset_n = 1'b1;
      tick();
      set_cpu(1'b1, 1'b0, 11'h010, 16'h0000, 2'b00);
      set_mcu(1'b1, 1'b0, 12'h021, 8'h00);
      tick();
      chk_all("pairA n+1", 1'b1, 16'hBEEF, 1'b0, 8'h00, 1'b0, 1'b0);
      idle();
      tick();
      chk_all("pairA n+2", 1'b0, 16'hBEEF, 1'b1, 8'hBE, 1'b0, 1'b0);
      tick();
      chk_all("pairA n+3", 1'b0, 16'hBEEF, 1'b0, 8'hBE, 1'b0, 1'b0);

      // Solo CPU grant leaves CPU as last grant, so the next conflict goes to the MCU.
      set_cpu(1'b1, 1'b0, 11'h011, 16'h0000, 2'b00);
      tick();
      chk("solo cpu_ack", {15'd0, cpu_ack}, 16'h0001);
      idle();
      tick();
      set_cpu(1'b1, 1'b0, 11'h010, 16'h0000, 2'b00);
      set_mcu(1'b1, 1'b0, 12'h020, 8'h00);
      tick();
      chk_all("pairB n+1", 1'b0, 16'hFF34, 1'b1, 8'hEF, 1'b0, 1'b0);
      idle();
      tick();
      chk_all("pairB n+2", 1'b1, 16'hBEEF, 1'b0, 8'hEF, 1'b0, 1'b0);
      tick();

      // Re-strobe while pending and during the ack cycle: both are ignored.
      set_cpu(1'b1, 1'b0, 11'h011, 16'h0000, 2'b00);
      set_mcu(1'b1, 1'b0, 12'h021, 8'h00);
      tick();
      chk_all("viol n+1", 1'b0, 16'hBEEF, 1'b1, 8'hBE, 1'b0, 1'b0);
      set_mcu(1'b0, 1'b0, 12'h000, 8'h00);
      set_cpu(1'b1, 1'b1, 11'h010, 16'h0000, 2'b11);
      tick();
      chk("viol n+2 cpu_ack", {15'd0, cpu_ack}, 16'h0001);
      chk("viol n+2 cpu_dout", cpu_dout, 16'hFF34);
      tick();
      chk("viol n+3 cpu_ack", {15'd0, cpu_ack}, 16'h0000);
      idle();
      tick();
      chk("viol n+4 cpu_ack", {15'd0, cpu_ack}, 16'h0000);
      set_cpu(1'b1, 1'b0, 11'h010, 16'h0000, 2'b00);
      tick();
      chk("viol readback", cpu_dout, 16'hBEEF);
      idle();
      tick();

      // Reset while an MCU write is pending: dropped, no ack, RAM retained.
      set_mcu(1'b1, 1'b0, 12'h020, 8'h00);
      tick();
      idle();
      tick();
      set_cpu(1'b1, 1'b0, 11'h010, 16'h0000, 2'b00);
      set_mcu(1'b1, 1'b1, 12'h020, 8'h99);
      tick();
      chk_all("rstmid n+1", 1'b1, 16'hBEEF, 1'b0, 8'hEF, 1'b0, 1'b0);
      idle();
      reset_n = 1'b0;
      #1;
      chk_all("rstmid async", 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      chk_all("rstmid hold", 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0);
      reset_n = 1'b1;
      tick();
      chk("rstmid post1 mcu_ack", {15'd0, mcu_ack}, 16'h0000);
      tick();
      chk("rstmid post2 mcu_ack", {15'd0, mcu_ack}, 16'h0000);
      set_mcu(1'b1, 1'b0, 12'h020, 8'h00);
      tick();
      chk("rstmid mcu_ack", {15'd0, mcu_ack}, 16'h0001);
      chk("rstmid mcu_dout", {8'd0, mcu_dout}, 16'h00EF);
      idle();
      tick();
      set_cpu(1'b1, 1'b0, 11'h010, 16'h0000, 2'b00);
      tick();
      chk("rstmid cpu_dout", cpu_dout, 16'hBEEF);
      idle();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
